// File: rtl/sptag_alloc.sv
// ---------------------------------------------------------------------------
// sptag_alloc : one-hot speculative-tag allocator with dependency tracking
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sptag_alloc #(
  parameter  int SPTAG_NUM = 5,
  localparam int CW        = $clog2(SPTAG_NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_1,
  input  logic                 i_req_2,
  input  logic                 i_id_valid,
  input  logic                 i_exfin_br_prsucc,
  input  logic                 i_exfin_br_prmiss,
  input  logic [SPTAG_NUM-1:0] i_exfin_br_sptag,
  output logic                 o_stall,
  output logic [SPTAG_NUM-1:0] o_sptag_1,
  output logic [SPTAG_NUM-1:0] o_sptag_2,
  output logic [SPTAG_NUM-1:0] o_spmask_1,
  output logic [SPTAG_NUM-1:0] o_spmask_2,
  output logic [SPTAG_NUM-1:0] o_busy,
  output logic [CW-1:0]        o_free_cnt
);

  logic [SPTAG_NUM-1:0] r_busy;
  logic [SPTAG_NUM-1:0] r_dep [SPTAG_NUM];

  logic [SPTAG_NUM-1:0] w_free;
  logic [SPTAG_NUM-1:0] w_low;
  logic [SPTAG_NUM-1:0] w_second;
  logic [SPTAG_NUM-1:0] w_kill;
  logic [SPTAG_NUM-1:0] w_succ_clr;
  logic [CW-1:0]        w_free_cnt;
  logic [1:0]           w_need;
  logic                 w_found0;
  logic                 w_found1;
  logic                 w_alloc;

  // Free count plus lowest and second-lowest free tag in one scan.
  always_comb begin
    w_free     = ~r_busy;
    w_free_cnt = '0;
    w_low      = '0;
    w_second   = '0;
    w_found0   = 1'b0;
    w_found1   = 1'b0;
    for (int i = 0; i < SPTAG_NUM; i++) begin
      if (w_free[i]) begin
        w_free_cnt = w_free_cnt + CW'(1);
        if (!w_found0) begin
          w_low[i] = 1'b1;
          w_found0 = 1'b1;
        end else if (!w_found1) begin
          w_second[i] = 1'b1;
          w_found1    = 1'b1;
        end
      end
    end
  end

  // A mispredict kills the tag itself and every tag allocated under it.
  always_comb begin
    w_kill = i_exfin_br_prmiss ? i_exfin_br_sptag : '0;
    for (int j = 0; j < SPTAG_NUM; j++) begin
      if (i_exfin_br_prmiss && |(r_dep[j] & i_exfin_br_sptag)) w_kill[j] = 1'b1;
    end
  end

  assign w_need     = {1'b0, i_req_1 & i_id_valid} + {1'b0, i_req_2 & i_id_valid};
  assign o_stall    = i_id_valid && (CW'(w_need) > w_free_cnt) && !i_exfin_br_prmiss;
  assign w_alloc    = i_id_valid && !o_stall && !i_exfin_br_prmiss;
  assign w_succ_clr = i_exfin_br_prsucc ? i_exfin_br_sptag : '0;

  assign o_sptag_1  = (w_alloc && i_req_1) ? w_low : '0;
  assign o_sptag_2  = (w_alloc && i_req_2) ? (i_req_1 ? w_second : w_low) : '0;
  assign o_spmask_1 = r_busy & ~w_succ_clr;
  assign o_spmask_2 = o_spmask_1 | o_sptag_1;
  assign o_busy     = r_busy;
  assign o_free_cnt = w_free_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int j = 0; j < SPTAG_NUM; j++) r_dep[j] <= '0;
    end else if (i_exfin_br_prmiss) begin
      r_busy <= r_busy & ~w_kill;
      for (int j = 0; j < SPTAG_NUM; j++)
        r_dep[j] <= w_kill[j] ? '0 : (r_dep[j] & ~w_kill);
    end else begin
      r_busy <= (r_busy & ~w_succ_clr) | o_sptag_1 | o_sptag_2;
      for (int j = 0; j < SPTAG_NUM; j++) begin
        if (o_sptag_1[j])       r_dep[j] <= o_spmask_1;
        else if (o_sptag_2[j])  r_dep[j] <= o_spmask_2;
        else if (w_succ_clr[j]) r_dep[j] <= '0;
        else                    r_dep[j] <= r_dep[j] & ~w_succ_clr;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/sptag_alloc.md
Name: sptag_alloc

Overview:
- Allocator and scheduler for the one-hot speculative-tag (SPTAG) pool used by the mispredict-fix logic.
- Sits in decode.
  - Grants up to two free tags per cycle to speculative (branch) instructions, in program order.
  - Tracks which older tags each live tag depends on.
  - Returns tags to the pool on branch success or misprediction.
- Provides decode with a stall signal and the speculative mask each instruction must carry.

Parameters:
SPTAG_NUM, 5, number of tags in the pool; each tag is a one-hot vector of width SPTAG_NUM.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req_1  in  1  decode slot 1 is a speculative instruction requesting a tag
i_req_2  in  1  decode slot 2 (younger) requests a tag
i_id_valid  in  1  decode bundle valid this cycle
i_exfin_br_prsucc  in  1  branch resolved correctly
i_exfin_br_prmiss  in  1  branch mispredicted
i_exfin_br_sptag  in  SPTAG_NUM  one-hot tag of the resolving branch
o_stall  out  1  insufficient free tags; decode must hold the bundle
o_sptag_1  out  SPTAG_NUM  one-hot tag granted to slot 1 (0 if none)
o_sptag_2  out  SPTAG_NUM  one-hot tag granted to slot 2 (0 if none)
o_spmask_1  out  SPTAG_NUM  outstanding tags slot 1 depends on
o_spmask_2  out  SPTAG_NUM  outstanding tags slot 2 depends on
o_busy  out  SPTAG_NUM  currently allocated tags
o_free_cnt  out  $clog2(SPTAG_NUM+1)  number of free tags

Behaviour:
- State:
  - busy[SPTAG_NUM-1:0].
  - dep[i][SPTAG_NUM-1:0] for each tag i: the older tags outstanding when i was allocated, minus any resolved since.
- Reset (rst_n=0 at posedge): busy=0, all dep=0.
  - Outputs after reset: o_busy=0, o_free_cnt=SPTAG_NUM, o_stall=0, grants=0.
- Combinational grant (all outputs derived from current-cycle state, zero latency):
  - need = i_req_1 + i_req_2, gated by i_id_valid.
  - o_stall = i_id_valid && need > o_free_cnt && !i_exfin_br_prmiss.
  - Free tags come from ~busy only; a tag freed this cycle is not reusable until the next cycle.
  - Slot 1 takes the lowest-index free tag. Slot 2 takes the lowest free tag, or the second-lowest if slot 1 also requested.
  - All-or-nothing: if o_stall=1 or prmiss=1, both grants are 0 and no state is allocated.
- Speculative masks:
  - o_spmask_1 = busy & ~succ_clr.
  - o_spmask_2 = o_spmask_1 | o_sptag_1.
  - succ_clr = i_exfin_br_sptag when prsucc, else 0.
- Sequential update, priority prmiss > (prsucc + alloc):
  - prmiss on tag t:
    - Free t and every tag j with dep[j][t]=1, i.e. busy &= ~(t | younger).
    - Clear dep of the freed tags.
    - No allocation this cycle.
  - prsucc on tag t:
    - busy[t]<=0 and dep[t]<=0.
    - Bit t cleared in every dep[j].
    - Allocation in the same cycle proceeds.
  - alloc:
    - busy |= o_sptag_1 | o_sptag_2.
    - dep[g1] <= o_spmask_1 and dep[g2] <= o_spmask_2.
- prsucc and prmiss asserted together is illegal; treated as prmiss.
- Resolution of a tag that is not busy is a no-op for busy; dep bits are still cleared.
- Full pool with need=0: no stall.
- Reset mid-operation discards all outstanding tags.

Test Plan:
1. Reset, then req_1=req_2=1 with SPTAG_NUM=5:
   - o_sptag_1=00001, o_sptag_2=00010, o_spmask_2=00001, o_stall=0.
   - Next cycle o_busy=00011, o_free_cnt=3.
2. Pool holds 4 tags, both slots request:
   - o_stall=1, grants=0, busy unchanged.
   - With a single request instead: grant 10000, o_free_cnt=0 next cycle.
3. Allocate tags 0, 1, 2 in order over three cycles, then prmiss on 00010:
   - Next cycle o_busy=00001, dep of tags 1 and 2 cleared.
4. Allocate 0, 1, 2, then prsucc on 00001 in the same cycle as req_1:
   - Grant 01000 with o_spmask_1=00110.
   - Next cycle o_busy=01110, dep[1]=0, dep[2]=00010.
5. prmiss and req_1 in the same cycle:
   - o_sptag_1=0, o_stall=0.
   - No new tag allocated; younger tags freed.
6. rst_n=0 while busy=11111:
   - Next cycle o_busy=0, o_free_cnt=5, all dep=0.
